// File: rtl/alu_muldiv_ctl.sv
// EX-stage ALU decode plus HI/LO with an iterative DIVU (MULTU when MULDIV_MULTU_EN is defined).
// Decode is combinational; DIVU/MULTU hold busy for WIDTH cycles (1 for divide-by-zero), stalling the pipe.
module alu_muldiv_ctl #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       MUXsignal,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             start;
`ifdef MULDIV_MULTU_EN
  logic             is_mul;
  logic [WIDTH:0]   sum;
`endif

  always_comb begin
    ALUOperation = 3'b010;
    MUXsignal    = 2'b10;
    if (ALUOp == 2'b01) begin
      ALUOperation = 3'b110;
    end else if (ALUOp == 2'b10) begin
      case (Funct)
        6'd32:   ALUOperation = 3'b010;
        6'd34:   ALUOperation = 3'b110;
        6'd36:   ALUOperation = 3'b000;
        6'd37:   ALUOperation = 3'b001;
        6'd13:   ALUOperation = 3'b001;
        6'd42:   ALUOperation = 3'b111;
        6'd0:    ALUOperation = 3'b011;
        6'd16:   MUXsignal    = 2'b00;
        6'd18:   MUXsignal    = 2'b01;
        default: ALUOperation = 3'b010;
      endcase
    end
  end

  assign start = valid_in && (ALUOp == 2'b10) && (state == IDLE);

  // dvd doubles as the quotient shift register (divide) or the low product half (multiply)
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
    end
`ifdef MULDIV_MULTU_EN
    sum = {1'b0, rem} + (dvd[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
    if (is_mul) begin
      rem_nxt = sum[WIDTH:1];
      dvd_nxt = {sum[0], dvd[WIDTH-1:1]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_MULTU_EN
      is_mul   <= 1'b0;
`endif
    end else begin
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (Funct)
              6'd27: begin
                dvd  <= src_a;
                dvs  <= src_b;
                rem  <= '0;
                busy <= 1'b1;
`ifdef MULDIV_MULTU_EN
                is_mul <= 1'b0;
`endif
                if (src_b == '0) begin
                  state    <= FIN;
                  div_zero <= 1'b1;
                end else begin
                  state <= DIV;
                  cnt   <= CNT_W'(WIDTH);
                end
              end
`ifdef MULDIV_MULTU_EN
              6'd25: begin
                dvd    <= src_b;
                dvs    <= src_a;
                rem    <= '0;
                is_mul <= 1'b1;
                cnt    <= CNT_W'(WIDTH);
                state  <= DIV;
                busy   <= 1'b1;
              end
`endif
              6'd17:   hi <= src_a;
              6'd19:   lo <= src_a;
              default: ;
            endcase
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - 1'b1;
          // the final step's result goes straight to HI/LO so they update atomically
          if (cnt == CNT_W'(1)) begin
            hi    <= rem_nxt;
            lo    <= dvd_nxt;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          lo    <= '1;
          hi    <= dvd;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctl.sv
// Bench for alu_muldiv_ctl: decode table, directed multi-cycle sequences and random DIVU/MULTU vs arithmetic model.
module tb_alu_muldiv_ctl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   ALUOp;
  logic [5:0]   Funct;
  logic         valid_in;
  logic [W-1:0] src_a, src_b;
  logic [2:0]   ALUOperation;
  logic [1:0]   MUXsignal;
  logic         busy;
  logic [W-1:0] hi, lo;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_ctl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct(Funct), .valid_in(valid_in),
    .src_a(src_a), .src_b(src_b), .ALUOperation(ALUOperation), .MUXsignal(MUXsignal),
    .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [2:0] eop;
    logic [1:0] emux;
  } dvec_t;

  dvec_t dv[$];

  int unsigned rf[9] = '{32, 34, 36, 37, 13, 42, 0, 16, 18};
  logic [2:0]  ro[9] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b001, 3'b111, 3'b011, 3'b010, 3'b010};
  logic [1:0]  rm[9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                  output logic [2:0] eop, output logic [1:0] emux);
    eop  = 3'b010;
    emux = 2'b10;
    if (op == 2'b01) eop = 3'b110;
    if (op == 2'b10)
      for (int i = 0; i < 9; i++)
        if (int'(f) == rf[i]) begin
          eop  = ro[i];
          emux = rm[i];
        end
  endfunction

  // Presents one R-type op, then counts busy / div_zero cycles and watches HI/LO for mid-op changes.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_mflo, output int bc, output int dz, output bit stable);
    logic [W-1:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    valid_in = 1'b1; ALUOp = 2'b10; Funct = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    if (hold_mflo) Funct = 6'd18;
    bc = 0; dz = 0; stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (div_zero) dz++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
    end
    if (!hold_mflo) valid_in = 1'b0;
  endtask

  initial begin
    int bc, dz;
    bit st;
    logic [2:0]  eop;
    logic [1:0]  emux;
    logic [W-1:0] a, b;
    logic [63:0] prod;
    logic [5:0]  f;

    rst_n = 1'b0; valid_in = 1'b0; ALUOp = 2'b10; Funct = 6'd32; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_aluop", 64'(ALUOperation), 64'(3'b010));
    chk("reset_mux", 64'(MUXsignal), 64'(2'b10));
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_divzero", 64'(div_zero), 64'd0);

    dv.push_back('{2'b00, 6'd34, 3'b010, 2'b10});
    dv.push_back('{2'b01, 6'd36, 3'b110, 2'b10});
    dv.push_back('{2'b10, 6'd32, 3'b010, 2'b10});
    dv.push_back('{2'b10, 6'd34, 3'b110, 2'b10});
    dv.push_back('{2'b10, 6'd36, 3'b000, 2'b10});
    dv.push_back('{2'b10, 6'd37, 3'b001, 2'b10});
    dv.push_back('{2'b10, 6'd13, 3'b001, 2'b10});
    dv.push_back('{2'b10, 6'd42, 3'b111, 2'b10});
    dv.push_back('{2'b10, 6'd0,  3'b011, 2'b10});
    dv.push_back('{2'b10, 6'd16, 3'b010, 2'b00});
    dv.push_back('{2'b10, 6'd18, 3'b010, 2'b01});
    dv.push_back('{2'b10, 6'd27, 3'b010, 2'b10});
    dv.push_back('{2'b10, 6'd25, 3'b010, 2'b10});
    dv.push_back('{2'b10, 6'd63, 3'b010, 2'b10});
    dv.push_back('{2'b11, 6'd42, 3'b010, 2'b10});
    dv.push_back('{2'b11, 6'd16, 3'b010, 2'b10});
    foreach (dv[i]) begin
      ALUOp = dv[i].op; Funct = dv[i].f; #1;
      chk($sformatf("dec_op[%0d]", i), 64'(ALUOperation), 64'(dv[i].eop));
      chk($sformatf("dec_mux[%0d]", i), 64'(MUXsignal), 64'(dv[i].emux));
    end

    for (int i = 0; i < 40; i++) begin
      ALUOp = 2'($urandom_range(0, 3)); Funct = 6'($urandom_range(0, 63)); #1;
      ref_dec(ALUOp, Funct, eop, emux);
      chk("rand_dec_op", 64'(ALUOperation), 64'(eop));
      chk("rand_dec_mux", 64'(MUXsignal), 64'(emux));
    end

    run_op(6'd27, 32'd100, 32'd7, 1'b0, bc, dz, st);
    chk("div100_7_busy", 64'(bc), 64'd32);
    chk("div100_7_lo", 64'(lo), 64'd14);
    chk("div100_7_hi", 64'(hi), 64'd2);
    chk("div100_7_dz", 64'(dz), 64'd0);
    chk("div100_7_stable", 64'(st), 64'd1);

    run_op(6'd27, 32'd5, 32'd0, 1'b0, bc, dz, st);
    chk("divz_busy", 64'(bc), 64'd1);
    chk("divz_pulse", 64'(dz), 64'd1);
    chk("divz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divz_hi", 64'(hi), 64'd5);
    chk("divz_pulse_gone", 64'(div_zero), 64'd0);

    run_op(6'd27, 32'd9, 32'd3, 1'b1, bc, dz, st);
    chk("mflo_stall_busy", 64'(bc), 64'd32);
    chk("mflo_stall_mux", 64'(MUXsignal), 64'(2'b01));
    chk("mflo_stall_lo", 64'(lo), 64'd3);
    chk("mflo_stall_hi", 64'(hi), 64'd0);
    @(posedge clk); #1;
    chk("mflo_no_accept", 64'(busy), 64'd0);
    valid_in = 1'b0;

    @(negedge clk);
    valid_in = 1'b1; ALUOp = 2'b10; Funct = 6'd17; src_a = 32'hCAFE0001;
    @(posedge clk); #1;
    chk("mthi_hi", 64'(hi), 64'hCAFE0001);
    chk("mthi_busy", 64'(busy), 64'd0);
    Funct = 6'd19; src_a = 32'h1234ABCD;
    @(posedge clk); #1;
    chk("mtlo_lo", 64'(lo), 64'h1234ABCD);
    chk("mtlo_hi_kept", 64'(hi), 64'hCAFE0001);
    chk("mtlo_busy", 64'(busy), 64'd0);
    ALUOp = 2'b00; Funct = 6'd27; src_a = 32'd50; src_b = 32'd5;
    @(posedge clk); #1;
    chk("nonrtype_no_start", 64'(busy), 64'd0);
    valid_in = 1'b0;

    @(negedge clk);
    valid_in = 1'b1; ALUOp = 2'b10; Funct = 6'd27; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; ALUOp = 2'b10; Funct = 6'd42; #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    chk("reset_decode_live", 64'(ALUOperation), 64'(3'b111));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6'd27, 32'd9, 32'd3, 1'b0, bc, dz, st);
    chk("post_reset_lo", 64'(lo), 64'd3);
    chk("post_reset_hi", 64'(hi), 64'd0);

    run_op(6'd25, 32'hFFFFFFFF, 32'd2, 1'b0, bc, dz, st);
`ifdef MULDIV_MULTU_EN
    chk("multu_busy", 64'(bc), 64'd32);
    chk("multu_hi", 64'(hi), 64'd1);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFE);
`else
    chk("multu_off_busy", 64'(bc), 64'd0);
    chk("multu_off_hi", 64'(hi), 64'd0);
    chk("multu_off_lo", 64'(lo), 64'd3);
`endif

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = a;
      endcase
      f = 6'd27;
`ifdef MULDIV_MULTU_EN
      if ($urandom_range(0, 2) == 0) f = 6'd25;
`endif
      run_op(f, a, b, 1'b0, bc, dz, st);
      if (f == 6'd25) begin
        prod = 64'(a) * 64'(b);
        chk("rnd_mul_busy", 64'(bc), 64'd32);
        chk("rnd_mul_prod", {hi, lo}, prod);
      end else if (b == '0) begin
        chk("rnd_divz_busy", 64'(bc), 64'd1);
        chk("rnd_divz_pulse", 64'(dz), 64'd1);
        chk("rnd_divz_lo", 64'(lo), 64'hFFFFFFFF);
        chk("rnd_divz_hi", 64'(hi), 64'(a));
      end else begin
        chk("rnd_div_busy", 64'(bc), 64'd32);
        chk("rnd_div_pulse", 64'(dz), 64'd0);
        chk("rnd_div_lo", 64'(lo), 64'(a / b));
        chk("rnd_div_hi", 64'(hi), 64'(a % b));
      end
      chk("rnd_stable", 64'(st), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
